// File: rtl/f2_issue_queue.sv
// F2 fetch issue queue: buffers in-order instruction-memory responses for D1 and
// owns the fetch epoch bit used to discard responses issued before a D1 flush.
module f2_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        IM_RespValid,
  output logic        IM_RespReady,
  input  logic [31:0] IM_RespData,
  input  logic [31:0] IM_RespPC,
  input  logic        IM_RespIsBDS,
  input  logic        IM_RespException,
  input  logic [4:0]  IM_RespExcCode,
  input  logic        IM_RespXOPRestart,
  input  logic        IM_RespEpoch,
  output logic        F2_Epoch,
  input  logic        D1_Stall,
  input  logic        D1_Flush,
  output logic        F2_Issued,
  output logic [31:0] F2_Instruction,
  output logic [31:0] F2_FetchPC,
  output logic [31:0] F2_PCAdd4,
  output logic        F2_IsBDS,
  output logic        F2_Exception,
  output logic [4:0]  F2_ExcCode,
  output logic        F2_XOP_Restart
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bds;
    logic        exc;
    logic [4:0]  code;
    logic        xop;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry_s;
  entry_t          head_s;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             epoch_q, epoch_d;
  logic             issued_s;
  logic             accept_s;
  logic             enq_s;
  logic             pop_s;

  assign issued_s     = (count_q != CNT_ZERO);
  assign IM_RespReady = (count_q != CNT_FULL);
  assign F2_Epoch     = epoch_q;
  assign accept_s     = IM_RespValid & IM_RespReady;
  // Stale-epoch or flush-cycle responses are consumed but never stored.
  assign enq_s        = accept_s & (IM_RespEpoch == epoch_q) & ~D1_Flush;
  assign pop_s        = issued_s & ~D1_Stall & ~D1_Flush;

  assign wr_entry_s = '{instr: IM_RespData, pc: IM_RespPC, bds: IM_RespIsBDS,
                        exc: IM_RespException, code: IM_RespExcCode,
                        xop: IM_RespXOPRestart};

  // Next-state for pointers, occupancy and epoch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    epoch_d  = epoch_q;
    if (D1_Flush) begin
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
      epoch_d  = ~epoch_q;
    end else begin
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= PTR_ZERO;
      wr_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      epoch_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      epoch_q  <= epoch_d;
    end
  end

  // Entry storage; deliberately not reset since count gates every read.
  always_ff @(posedge clock) begin
    if (enq_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    head_s = '0;
    if (issued_s) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '0;
    end
  end

  assign F2_Issued      = issued_s;
  assign F2_Instruction = head_s.instr;
  assign F2_FetchPC     = head_s.pc;
  assign F2_PCAdd4      = issued_s ? (head_s.pc + 32'd4) : 32'd0;
  assign F2_IsBDS       = head_s.bds;
  assign F2_Exception   = head_s.exc;
  assign F2_ExcCode     = head_s.code;
  assign F2_XOP_Restart = head_s.xop;

endmodule

// File: tb/tb_f2_issue_queue.sv
// Directed self-checking bench for f2_issue_queue.
module tb_f2_issue_queue;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        IM_RespValid, IM_RespReady;
  logic [31:0] IM_RespData, IM_RespPC;
  logic        IM_RespIsBDS, IM_RespException, IM_RespXOPRestart, IM_RespEpoch;
  logic [4:0]  IM_RespExcCode;
  logic        F2_Epoch, D1_Stall, D1_Flush, F2_Issued;
  logic [31:0] F2_Instruction, F2_FetchPC, F2_PCAdd4;
  logic        F2_IsBDS, F2_Exception, F2_XOP_Restart;
  logic [4:0]  F2_ExcCode;

  int n_checks = 0;
  int n_fail   = 0;
  logic ep = 1'b0;

  always #5 clock = ~clock;

  f2_issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .IM_RespValid(IM_RespValid), .IM_RespReady(IM_RespReady),
    .IM_RespData(IM_RespData), .IM_RespPC(IM_RespPC),
    .IM_RespIsBDS(IM_RespIsBDS), .IM_RespException(IM_RespException),
    .IM_RespExcCode(IM_RespExcCode), .IM_RespXOPRestart(IM_RespXOPRestart),
    .IM_RespEpoch(IM_RespEpoch), .F2_Epoch(F2_Epoch),
    .D1_Stall(D1_Stall), .D1_Flush(D1_Flush), .F2_Issued(F2_Issued),
    .F2_Instruction(F2_Instruction), .F2_FetchPC(F2_FetchPC), .F2_PCAdd4(F2_PCAdd4),
    .F2_IsBDS(F2_IsBDS), .F2_Exception(F2_Exception), .F2_ExcCode(F2_ExcCode),
    .F2_XOP_Restart(F2_XOP_Restart)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic set_resp(input logic [31:0] pc, input logic e);
    IM_RespValid      = 1'b1;
    IM_RespPC         = pc;
    IM_RespData       = instr_of(pc);
    IM_RespIsBDS      = pc[2];
    IM_RespException  = pc[3];
    IM_RespExcCode    = pc[8:4];
    IM_RespXOPRestart = pc[4];
    IM_RespEpoch      = e;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; IM_RespValid = 1'b0; D1_Stall = 1'b0; D1_Flush = 1'b0;
    set_resp(32'h0, 1'b0); IM_RespValid = 1'b0;
    #12;
    n_checks++;
    if (F2_Issued !== 1'b0 || IM_RespReady !== 1'b1 || F2_Epoch !== 1'b0 || F2_FetchPC !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: issued=%b ready=%b epoch=%b pc=%h, required 0/1/0/0", F2_Issued, IM_RespReady, F2_Epoch, F2_FetchPC);
    end
    @(posedge clock); #1; reset_n = 1'b1;
    tick();
    n_checks++;
    if (F2_Issued !== 1'b0 || IM_RespReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: issued=%b ready=%b, required 0/1", F2_Issued, IM_RespReady);
    end
  endtask

  task automatic test_stream3();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'(4 * i);
      set_resp(pc, ep);
      tick();
      n_checks++;
      if (F2_Issued !== 1'b1 || F2_FetchPC !== pc || F2_PCAdd4 !== pc + 32'd4 || F2_Instruction !== instr_of(pc)) begin
        n_fail++;
        $display("FAIL stream3[%0d]: issued=%b pc=%h add4=%h ins=%h, required 1/%h/%h/%h", i, F2_Issued, F2_FetchPC, F2_PCAdd4, F2_Instruction, pc, pc + 32'd4, instr_of(pc));
      end
    end
    IM_RespValid = 1'b0;
    tick();
    n_checks++;
    if (F2_Issued !== 1'b0) begin
      n_fail++;
      $display("FAIL stream3_drain: issued=%b, required 0", F2_Issued);
    end
  endtask

  task automatic test_full_stall();
    D1_Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_resp(32'h200 + 32'(4 * i), ep);
      n_checks++;
      if (IM_RespReady !== (i < 4)) begin
        n_fail++;
        $display("FAIL full_ready[%0d]: ready=%b, required %b", i, IM_RespReady, (i < 4));
      end
      if (i < 4) tick();
    end
    D1_Stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (F2_Issued !== 1'b1 || F2_FetchPC !== 32'h200 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: issued=%b pc=%h, required 1/%h", k, F2_Issued, F2_FetchPC, 32'h200 + 32'(4 * k));
      end
      tick();
      if (k == 1) IM_RespValid = 1'b0;
    end
    n_checks++;
    if (F2_Issued !== 1'b0 || IM_RespReady !== 1'b1) begin
      n_fail++;
      $display("FAIL full_empty: issued=%b ready=%b, required 0/1", F2_Issued, IM_RespReady);
    end
  endtask

  task automatic test_flush();
    D1_Stall = 1'b1;
    set_resp(32'h300, ep); tick();
    set_resp(32'h304, ep); tick();
    set_resp(32'h308, ep); D1_Flush = 1'b1;
    tick();
    D1_Flush = 1'b0; ep = ~ep;
    n_checks++;
    if (F2_Issued !== 1'b0 || F2_Epoch !== ep || IM_RespReady !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: issued=%b epoch=%b ready=%b, required 0/%b/1", F2_Issued, F2_Epoch, IM_RespReady, ep);
    end
    set_resp(32'h400, ~ep); tick();
    n_checks++;
    if (F2_Issued !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_drop: issued=%b pc=%h, required 0", F2_Issued, F2_FetchPC);
    end
    set_resp(32'h404, ep); tick();
    IM_RespValid = 1'b0;
    n_checks++;
    if (F2_Issued !== 1'b1 || F2_FetchPC !== 32'h404) begin
      n_fail++;
      $display("FAIL new_epoch: issued=%b pc=%h, required 1/00000404", F2_Issued, F2_FetchPC);
    end
    D1_Stall = 1'b0; tick();
    D1_Flush = 1'b1; tick();
    D1_Flush = 1'b1; tick();
    D1_Flush = 1'b0;
    n_checks++;
    if (F2_Epoch !== ep) begin
      n_fail++;
      $display("FAIL double_flush: epoch=%b, required %b", F2_Epoch, ep);
    end
  endtask

  task automatic test_pc_wrap();
    set_resp(32'hFFFF_FFFC, ep);
    IM_RespIsBDS = 1'b1; IM_RespException = 1'b1; IM_RespExcCode = 5'd4; IM_RespXOPRestart = 1'b1;
    D1_Stall = 1'b1;
    tick();
    IM_RespValid = 1'b0;
    n_checks++;
    if (F2_PCAdd4 !== 32'h0 || F2_IsBDS !== 1'b1 || F2_Exception !== 1'b1 || F2_ExcCode !== 5'd4 || F2_XOP_Restart !== 1'b1) begin
      n_fail++;
      $display("FAIL pc_wrap: add4=%h bds=%b exc=%b code=%0d xop=%b, required 0/1/1/4/1", F2_PCAdd4, F2_IsBDS, F2_Exception, F2_ExcCode, F2_XOP_Restart);
    end
    D1_Stall = 1'b0; tick();
    n_checks++;
    if ({F2_Issued, F2_Instruction, F2_FetchPC, F2_PCAdd4, F2_IsBDS, F2_Exception, F2_ExcCode, F2_XOP_Restart} !== 104'h0) begin
      n_fail++;
      $display("FAIL empty_gating: issued=%b pc=%h add4=%h exc=%b code=%0d, required all 0", F2_Issued, F2_FetchPC, F2_PCAdd4, F2_Exception, F2_ExcCode);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    int sent = 0, got = 0, cyc = 0;
    logic acc, pop;
    while (got < 24 && cyc < 400) begin
      D1_Stall = ($urandom_range(0, 2) == 0);
      if (sent < 24) set_resp(32'h1000 + 32'(4 * sent), ep);
      else IM_RespValid = 1'b0;
      n_checks++;
      if (F2_Issued !== (exp_q.size() != 0) || IM_RespReady !== (exp_q.size() != 4)) begin
        n_fail++;
        $display("FAIL sb_flags: issued=%b ready=%b, required %b/%b", F2_Issued, IM_RespReady, exp_q.size() != 0, exp_q.size() != 4);
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        if (F2_FetchPC !== exp_q[0] || F2_Instruction !== instr_of(exp_q[0]) || F2_ExcCode !== exp_q[0][8:4] || F2_IsBDS !== exp_q[0][2]) begin
          n_fail++;
          $display("FAIL sb_head: pc=%h ins=%h code=%0d, required %h/%h/%0d", F2_FetchPC, F2_Instruction, F2_ExcCode, exp_q[0], instr_of(exp_q[0]), exp_q[0][8:4]);
        end
      end
      acc = IM_RespValid && (exp_q.size() != 4);
      pop = (exp_q.size() != 0) && !D1_Stall;
      tick();
      cyc++;
      if (pop) begin void'(exp_q.pop_front()); got++; end
      if (acc) begin exp_q.push_back(32'h1000 + 32'(4 * sent)); sent++; end
    end
    IM_RespValid = 1'b0; D1_Stall = 1'b0;
    n_checks++;
    if (got != 24 || F2_Issued !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_done: got=%0d issued=%b, required 24/0", got, F2_Issued);
    end
  endtask

  task automatic test_async_reset();
    D1_Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin set_resp(32'h500 + 32'(4 * i), ep); tick(); end
    IM_RespValid = 1'b0;
    n_checks++;
    if (F2_Epoch !== 1'b1 || F2_FetchPC !== 32'h500) begin
      n_fail++;
      $display("FAIL pre_reset: epoch=%b pc=%h, required 1/00000500", F2_Epoch, F2_FetchPC);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (F2_Issued !== 1'b0 || F2_Epoch !== 1'b0 || F2_FetchPC !== 32'h0 || IM_RespReady !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: issued=%b epoch=%b pc=%h ready=%b, required 0/0/0/1", F2_Issued, F2_Epoch, F2_FetchPC, IM_RespReady);
    end
    tick(); reset_n = 1'b1; D1_Stall = 1'b0; ep = 1'b0;
    tick();
    n_checks++;
    if (F2_Issued !== 1'b0 || IM_RespReady !== 1'b1 || F2_Epoch !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: issued=%b ready=%b epoch=%b, required 0/1/0", F2_Issued, IM_RespReady, F2_Epoch);
    end
  endtask

  initial begin
    test_reset();
    test_stream3();
    test_full_stall();
    test_flush();
    test_pc_wrap();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
